// File: rtl/alu_pe_scheduler.sv
// Request router and response arbiter for one ALU block's processing elements (INT, MULDIV, DOT8).
// Optional performance counters are enabled by defining ALU_PE_SCHED_PERF_EN.
module alu_pe_scheduler #(
   parameter int PE_COUNT = 3,
   parameter int DATA_W   = 64,
   parameter int RSP_W    = 64,
   parameter int CREDITS  = 4,
   localparam int SEL_W   = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1,
   localparam int CNT_W   = $clog2(CREDITS + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   input  logic [DATA_W-1:0]         req_data,
   input  logic [SEL_W-1:0]          req_pe_sel,
   output logic                      req_ready,
   output logic [PE_COUNT-1:0]       pe_req_valid,
   output logic [DATA_W-1:0]         pe_req_data,
   input  logic [PE_COUNT-1:0]       pe_req_ready,
   input  logic [PE_COUNT-1:0]       pe_rsp_valid,
   input  logic [PE_COUNT*RSP_W-1:0] pe_rsp_data,
   output logic [PE_COUNT-1:0]       pe_rsp_ready,
   output logic                      rsp_valid,
   output logic [RSP_W-1:0]          rsp_data,
   output logic [SEL_W-1:0]          rsp_pe_id,
   input  logic                      rsp_ready,
`ifdef ALU_PE_SCHED_PERF_EN
   output logic [31:0]               perf_credit_stall,
   output logic [31:0]               perf_rsp_stall,
`endif
   output logic                      busy,
   output logic                      err
);

   typedef struct packed {
      logic [RSP_W-1:0] data;
      logic [SEL_W-1:0] pe_id;
   } buf_entry_t;

   logic [CNT_W-1:0] cnt [PE_COUNT];
   logic [SEL_W-1:0] rr_ptr;
   buf_entry_t       buf_mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       buf_cnt;

   logic             sel_ok;
   logic [CNT_W-1:0] cnt_s;
   logic             rdy_s;
   logic             has_credit;
   logic             req_fire;
   logic             gnt_found;
   logic [SEL_W-1:0] gnt_idx;
   logic [RSP_W-1:0] gnt_data;
   logic             buf_free;
   logic             push;
   logic             pop;
   logic             underflow;
   logic             any_cnt;

   // Request routing: only an in-range select can see a credit or a ready.
   always_comb begin
      sel_ok = 1'b0;
      cnt_s  = '0;
      rdy_s  = 1'b0;
      for (int i = 0; i < PE_COUNT; i++) begin
         if (req_pe_sel == SEL_W'(i)) begin
            sel_ok = 1'b1;
            cnt_s  = cnt[i];
            rdy_s  = pe_req_ready[i];
         end
      end
      has_credit   = sel_ok && (cnt_s < CNT_W'(CREDITS));
      req_ready    = has_credit && rdy_s;
      req_fire     = req_valid && req_ready;
      pe_req_valid = '0;
      for (int i = 0; i < PE_COUNT; i++) begin
         pe_req_valid[i] = req_valid && has_credit && (req_pe_sel == SEL_W'(i));
      end
      pe_req_data = req_data;
   end

   // Cyclic search from rr_ptr; free slot uses registered occupancy so a full buffer never pushes.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < PE_COUNT; k++) begin
         if (!gnt_found && pe_rsp_valid[(int'(rr_ptr) + k) % PE_COUNT]) begin
            gnt_found = 1'b1;
            gnt_idx   = SEL_W'((int'(rr_ptr) + k) % PE_COUNT);
         end
      end
      gnt_data = '0;
      for (int i = 0; i < PE_COUNT; i++) begin
         if (gnt_idx == SEL_W'(i)) gnt_data = pe_rsp_data[i*RSP_W +: RSP_W];
      end
      buf_free     = (buf_cnt != 2'd2);
      push         = gnt_found && buf_free;
      pe_rsp_ready = '0;
      if (push) pe_rsp_ready[gnt_idx] = 1'b1;
      pop       = (buf_cnt != 2'd0) && rsp_ready;
      underflow = 1'b0;
      any_cnt   = 1'b0;
      for (int i = 0; i < PE_COUNT; i++) begin
         if (pe_rsp_valid[i] && pe_rsp_ready[i] && (cnt[i] == '0) &&
             !(req_fire && (req_pe_sel == SEL_W'(i))))
            underflow = 1'b1;
         if (cnt[i] != '0) any_cnt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PE_COUNT; i++) cnt[i] <= '0;
         rr_ptr  <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         buf_cnt <= 2'd0;
         err     <= 1'b0;
      end else begin
         for (int i = 0; i < PE_COUNT; i++) begin
            if (req_fire && (req_pe_sel == SEL_W'(i)) && !(pe_rsp_valid[i] && pe_rsp_ready[i]))
               cnt[i] <= cnt[i] + CNT_W'(1);
            else if (!(req_fire && (req_pe_sel == SEL_W'(i))) && pe_rsp_valid[i] &&
                     pe_rsp_ready[i] && (cnt[i] != '0))
               cnt[i] <= cnt[i] - CNT_W'(1);
         end
         if (push) begin
            rr_ptr <= SEL_W'((int'(gnt_idx) + 1) % PE_COUNT);
            wr_ptr <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   buf_cnt <= buf_cnt + 2'd1;
            2'b01:   buf_cnt <= buf_cnt - 2'd1;
            default: buf_cnt <= buf_cnt;
         endcase
         if ((req_valid && !sel_ok) || underflow) err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) buf_mem[wr_ptr] <= '{data: gnt_data, pe_id: gnt_idx};
   end

   assign rsp_valid = (buf_cnt != 2'd0);
   assign rsp_data  = buf_mem[rd_ptr].data;
   assign rsp_pe_id = buf_mem[rd_ptr].pe_id;
   assign busy      = any_cnt || (buf_cnt != 2'd0);

`ifdef ALU_PE_SCHED_PERF_EN
   logic credit_full;
   assign credit_full = sel_ok && (cnt_s == CNT_W'(CREDITS));

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_credit_stall <= '0;
         perf_rsp_stall    <= '0;
      end else begin
         if (req_valid && credit_full && (perf_credit_stall != '1))
            perf_credit_stall <= perf_credit_stall + 32'd1;
         if (rsp_valid && !rsp_ready && (perf_rsp_stall != '1))
            perf_rsp_stall <= perf_rsp_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_pe_scheduler.sv
// Directed bench for alu_pe_scheduler: credits, round-robin, back-pressure, errors, reset.
module tb_alu_pe_scheduler;

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid;
   logic [63:0]  req_data;
   logic [1:0]   req_pe_sel;
   logic         req_ready;
   logic [2:0]   pe_req_valid;
   logic [63:0]  pe_req_data;
   logic [2:0]   pe_req_ready;
   logic [2:0]   pe_rsp_valid;
   logic [191:0] pe_rsp_data;
   logic [2:0]   pe_rsp_ready;
   logic         rsp_valid;
   logic [63:0]  rsp_data;
   logic [1:0]   rsp_pe_id;
   logic         rsp_ready;
   logic         busy;
   logic         err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] pdat [3];

   always #5 clk = ~clk;

   alu_pe_scheduler dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_pe_sel(req_pe_sel), .req_ready(req_ready),
      .pe_req_valid(pe_req_valid), .pe_req_data(pe_req_data), .pe_req_ready(pe_req_ready),
      .pe_rsp_valid(pe_rsp_valid), .pe_rsp_data(pe_rsp_data), .pe_rsp_ready(pe_rsp_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_pe_id(rsp_pe_id), .rsp_ready(rsp_ready),
      .busy(busy), .err(err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic do_reset;
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_pe_sel   = 2'd0;
      pe_rsp_valid = 3'b000;
      rsp_ready    = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic issue(input int sel, input int n);
      req_valid  = 1'b1;
      req_pe_sel = 2'(sel);
      for (int k = 0; k < n; k++) begin
         req_data = 64'h1000 + 64'(k);
         settle();
         n_cmp++;
         if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL issue_ready pe%0d #%0d: got %b want 1", sel, k, req_ready);
         end
         tick();
      end
      req_valid = 1'b0;
   endtask

   task automatic drain(input int pe, input int n);
      rsp_ready    = 1'b1;
      pe_rsp_valid = 3'(1) << pe;
      for (int k = 0; k < n; k++) begin
         settle();
         n_cmp++;
         if (pe_rsp_ready !== (3'(1) << pe)) begin
            n_bad++;
            $display("FAIL drain_grant pe%0d #%0d: got %b want %b", pe, k, pe_rsp_ready, 3'(1) << pe);
         end
         tick();
      end
      pe_rsp_valid = 3'b000;
      tick();
      tick();
   endtask

   task automatic test_reset;
      do_reset();
      settle();
      n_cmp++;
      if (rsp_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: rsp_valid=%b err=%b busy=%b want 0 0 0", rsp_valid, err, busy);
      end
      n_cmp++;
      if (req_ready !== 1'b1 || pe_req_valid !== 3'b000 || pe_rsp_ready !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_ports: req_ready=%b pe_req_valid=%b pe_rsp_ready=%b want 1 000 000",
                  req_ready, pe_req_valid, pe_rsp_ready);
      end
   endtask

   task automatic test_credit_limit;
      int acc;
      acc        = 0;
      req_valid  = 1'b1;
      req_pe_sel = 2'd1;
      for (int k = 0; k < 6; k++) begin
         req_data = 64'hABCD_0000_0000_0000 + 64'(k);
         settle();
         if (k == 0) begin
            n_cmp++;
            if (pe_req_valid !== 3'b010 || pe_req_data !== req_data) begin
               n_bad++;
               $display("FAIL credit_first: pe_req_valid=%b data=%h want 010 %h", pe_req_valid, pe_req_data, req_data);
            end
         end
         if (req_ready === 1'b1) acc++;
         tick();
      end
      settle();
      n_cmp++;
      if (acc != 4) begin
         n_bad++;
         $display("FAIL credit_accepted: got %0d want 4", acc);
      end
      n_cmp++;
      if (req_ready !== 1'b0 || pe_req_valid !== 3'b000 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL credit_full: req_ready=%b pe_req_valid=%b busy=%b want 0 000 1", req_ready, pe_req_valid, busy);
      end
      req_pe_sel = 2'd0;
      settle();
      n_cmp++;
      if (req_ready !== 1'b1 || pe_req_valid !== 3'b001) begin
         n_bad++;
         $display("FAIL credit_other_pe: req_ready=%b pe_req_valid=%b want 1 001", req_ready, pe_req_valid);
      end
      req_pe_sel = 2'd1;
   endtask

   task automatic test_credit_return;
      rsp_ready    = 1'b1;
      pe_rsp_valid = 3'b010;
      settle();
      n_cmp++;
      if (pe_rsp_ready !== 3'b010 || req_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL return_grant: pe_rsp_ready=%b req_ready=%b want 010 0", pe_rsp_ready, req_ready);
      end
      tick();
      pe_rsp_valid = 3'b000;
      settle();
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL return_ready: got %b want 1", req_ready);
      end
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_pe_id !== 2'd1 || rsp_data !== pdat[1]) begin
         n_bad++;
         $display("FAIL return_commit: valid=%b id=%0d data=%h want 1 1 %h", rsp_valid, rsp_pe_id, rsp_data, pdat[1]);
      end
      tick();
      settle();
      n_cmp++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL return_refull: req_ready=%b rsp_valid=%b want 0 0", req_ready, rsp_valid);
      end
      req_valid = 1'b0;
      drain(1, 4);
      settle();
      n_cmp++;
      if (busy !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL return_idle: busy=%b err=%b want 0 0", busy, err);
      end
   endtask

   task automatic test_round_robin;
      do_reset();
      issue(0, 2);
      issue(1, 2);
      issue(2, 2);
      rsp_ready    = 1'b1;
      pe_rsp_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
         settle();
         n_cmp++;
         if (pe_rsp_ready !== (3'(1) << (c % 3))) begin
            n_bad++;
            $display("FAIL rr_grant c%0d: got %b want %b", c, pe_rsp_ready, 3'(1) << (c % 3));
         end
         if (c == 0) begin
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
               n_bad++;
               $display("FAIL rr_latency: rsp_valid=%b want 0", rsp_valid);
            end
         end
         tick();
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_pe_id !== 2'(c % 3) || rsp_data !== pdat[c % 3]) begin
            n_bad++;
            $display("FAIL rr_commit c%0d: valid=%b id=%0d data=%h want 1 %0d %h",
                     c, rsp_valid, rsp_pe_id, rsp_data, c % 3, pdat[c % 3]);
         end
      end
      pe_rsp_valid = 3'b000;
      tick();
      settle();
      n_cmp++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL rr_idle: rsp_valid=%b busy=%b err=%b want 0 0 0", rsp_valid, busy, err);
      end
   endtask

   task automatic test_back_pressure;
      int grants;
      logic [2:0] exp_rdy;
      do_reset();
      issue(0, 2);
      issue(1, 2);
      issue(2, 2);
      grants       = 0;
      rsp_ready    = 1'b0;
      pe_rsp_valid = 3'b111;
      for (int c = 0; c < 5; c++) begin
         settle();
         exp_rdy = (c < 2) ? (3'(1) << c) : 3'b000;
         if (pe_rsp_ready !== 3'b000) grants++;
         n_cmp++;
         if (pe_rsp_ready !== exp_rdy) begin
            n_bad++;
            $display("FAIL bp_grant c%0d: got %b want %b", c, pe_rsp_ready, exp_rdy);
         end
         tick();
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_pe_id !== 2'd0 || rsp_data !== pdat[0]) begin
            n_bad++;
            $display("FAIL bp_stable c%0d: valid=%b id=%0d data=%h want 1 0 %h", c, rsp_valid, rsp_pe_id, rsp_data, pdat[0]);
         end
      end
      n_cmp++;
      if (grants != 2) begin
         n_bad++;
         $display("FAIL bp_grants: got %0d want 2", grants);
      end
      pe_rsp_valid = 3'b000;
      rsp_ready    = 1'b1;
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_pe_id !== 2'd1 || rsp_data !== pdat[1]) begin
         n_bad++;
         $display("FAIL bp_second: valid=%b id=%0d data=%h want 1 1 %h", rsp_valid, rsp_pe_id, rsp_data, pdat[1]);
      end
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_empty: rsp_valid=%b want 0", rsp_valid);
      end
      drain(0, 1);
      drain(1, 1);
      drain(2, 2);
      settle();
      n_cmp++;
      if (busy !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_idle: busy=%b err=%b want 0 0", busy, err);
      end
   endtask

   task automatic test_simultaneous;
      do_reset();
      issue(2, 1);
      req_valid    = 1'b1;
      req_pe_sel   = 2'd2;
      pe_rsp_valid = 3'b100;
      rsp_ready    = 1'b1;
      settle();
      n_cmp++;
      if (req_ready !== 1'b1 || pe_rsp_ready !== 3'b100) begin
         n_bad++;
         $display("FAIL simul_fire: req_ready=%b pe_rsp_ready=%b want 1 100", req_ready, pe_rsp_ready);
      end
      tick();
      req_valid    = 1'b0;
      pe_rsp_valid = 3'b000;
      settle();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_pe_id !== 2'd2) begin
         n_bad++;
         $display("FAIL simul_commit: valid=%b id=%0d want 1 2", rsp_valid, rsp_pe_id);
      end
      tick();
      tick();
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL simul_cnt_held: busy=%b want 1", busy);
      end
      drain(2, 1);
      settle();
      n_cmp++;
      if (busy !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL simul_idle: busy=%b err=%b want 0 0", busy, err);
      end
   endtask

   task automatic test_errors;
      do_reset();
      req_valid  = 1'b1;
      req_pe_sel = 2'd3;
      settle();
      n_cmp++;
      if (req_ready !== 1'b0 || pe_req_valid !== 3'b000 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL illegal_sel: req_ready=%b pe_req_valid=%b err=%b want 0 000 0", req_ready, pe_req_valid, err);
      end
      tick();
      req_valid = 1'b0;
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL illegal_err: err=%b want 1", err);
      end
      tick();
      tick();
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL err_sticky: err=%b want 1", err);
      end
      do_reset();
      settle();
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL err_reset: err=%b want 0", err);
      end
      pe_rsp_valid = 3'b001;
      rsp_ready    = 1'b1;
      settle();
      n_cmp++;
      if (pe_rsp_ready !== 3'b001) begin
         n_bad++;
         $display("FAIL underflow_grant: got %b want 001", pe_rsp_ready);
      end
      tick();
      pe_rsp_valid = 3'b000;
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL underflow_err: err=%b want 1", err);
      end
      tick();
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL underflow_cnt: busy=%b want 0", busy);
      end
      issue(1, 1);
      rsp_ready    = 1'b0;
      pe_rsp_valid = 3'b010;
      tick();
      pe_rsp_valid = 3'b000;
      settle();
      n_cmp++;
      if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL midop_pre: rsp_valid=%b busy=%b want 1 1", rsp_valid, busy);
      end
      do_reset();
      settle();
      n_cmp++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL midop_reset: rsp_valid=%b busy=%b err=%b want 0 0 0", rsp_valid, busy, err);
      end
   endtask

   initial begin
      pdat[0]      = 64'h0123_4567_89AB_CDEF;
      pdat[1]      = 64'hFEDC_BA98_7654_3210;
      pdat[2]      = 64'h5A5A_A5A5_0F0F_F0F0;
      pe_rsp_data  = {pdat[2], pdat[1], pdat[0]};
      pe_req_ready = 3'b111;
      req_data     = 64'h0;
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_pe_sel   = 2'd0;
      pe_rsp_valid = 3'b000;
      rsp_ready    = 1'b1;
      test_reset();
      test_credit_limit();
      test_credit_return();
      test_round_robin();
      test_back_pressure();
      test_simultaneous();
      test_errors();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
